// File: rtl/apb_controller_fsm.sv
// AHB-to-APB bridge controller: sequences APB setup/enable phases for AHB
// reads and (optionally pipelined) writes, with all APB outputs registered.
module apb_controller_fsm (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        valid,
    input  logic [31:0] haddr,
    input  logic [31:0] haddr_1,
    input  logic [31:0] haddr_2,
    input  logic [31:0] hwdata,
    input  logic [31:0] hwdata_1,
    input  logic        hwrite,
    input  logic        hwrite_reg_1,
    output logic        pwrite,
    output logic        penable,
    output logic [2:0]  psel,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        hreadyout
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RENABLE,
        ST_WWAIT,
        ST_WRITE,
        ST_WRITEP,
        ST_WENABLE,
        ST_WENABLEP
    } state_e;

    state_e      state_q, state_d;
    logic        pwrite_q, pwrite_d;
    logic        penable_q, penable_d;
    logic [2:0]  psel_q, psel_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        hreadyout_q, hreadyout_d;

    // Peripheral select from the top address bits; unmapped regions select nothing.
    function automatic logic [2:0] decode(input logic [5:0] region);
        case (region)
            6'h20:   return 3'b001;
            6'h21:   return 3'b010;
            6'h22:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Next state, plus the output values that must be visible while in that state.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = 3'b000;
        penable_d   = 1'b0;
        hreadyout_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (valid) state_d = hwrite ? ST_WWAIT : ST_READ;
            end
            ST_READ:   state_d = ST_RENABLE;
            ST_WRITEP: state_d = ST_WENABLEP;
            ST_WWAIT:  state_d = valid ? ST_WRITEP : ST_WRITE;
            ST_WRITE:  state_d = valid ? ST_WENABLEP : ST_WENABLE;
            ST_RENABLE, ST_WENABLE: begin
                if (!valid)      state_d = ST_IDLE;
                else if (hwrite) state_d = ST_WWAIT;
                else             state_d = ST_READ;
            end
            ST_WENABLEP: begin
                if (!hwrite_reg_1) state_d = ST_READ;
                else if (valid)    state_d = ST_WRITEP;
                else               state_d = ST_WRITE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        case (state_d)
            ST_READ: begin
                paddr_d     = haddr;
                pwrite_d    = 1'b0;
                psel_d      = decode(haddr[31:26]);
                hreadyout_d = 1'b0;
            end
            ST_WRITE, ST_WRITEP: begin
                // Coming from WENABLEP the pending write is one stage further down the pipe.
                if (state_q == ST_WENABLEP) begin
                    paddr_d  = haddr_2;
                    pwdata_d = hwdata_1;
                end else begin
                    paddr_d  = haddr_1;
                    pwdata_d = hwdata;
                end
                pwrite_d    = 1'b1;
                psel_d      = decode(paddr_d[31:26]);
                hreadyout_d = (state_d != ST_WRITEP);
            end
            ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                psel_d    = psel_q;
                penable_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State and output registers; reset aborts any transfer immediately.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q     <= ST_IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 3'b000;
            penable_q   <= 1'b0;
            hreadyout_q <= 1'b1;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            hreadyout_q <= hreadyout_d;
        end
    end

    assign pwrite    = pwrite_q;
    assign penable   = penable_q;
    assign psel      = psel_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign hreadyout = hreadyout_q;

endmodule

// File: doc/apb_controller_fsm.md
APB_CONTROLLER_FSM -- requirements
Module: apb_controller_fsm

Interface
REQ-001 SHALL have port hclk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port hreset, input, 1, reset; asynchronous and active-high.
REQ-003 SHALL have port valid, input, 1, qualified AHB transfer request from the slave interface.
REQ-004 SHALL have ports haddr, haddr_1 and haddr_2, input, 32 each; address of the current, 1-cycle-delayed and 2-cycle-delayed transfer.
REQ-005 SHALL have ports hwdata and hwdata_1, input, 32 each; write data, current and 1-cycle-delayed.
REQ-006 SHALL have ports hwrite and hwrite_reg_1, input, 1 each; write flag, current and 1-cycle-delayed.
REQ-007 SHALL have port pwrite, output, 1, APB direction (1 = write).
REQ-008 SHALL have port penable, output, 1, APB enable phase.
REQ-009 SHALL have port psel, output, 3, one-hot peripheral select.
REQ-010 SHALL have port paddr, output, 32, APB address.
REQ-011 SHALL have port pwdata, output, 32, APB write data.
REQ-012 SHALL have port hreadyout, output, 1, AHB ready back to master; 0 = insert wait state.

Function
REQ-013 SHALL implement 8 states: IDLE, READ, RENABLE, WWAIT, WRITE, WRITEP, WENABLE, WENABLEP.
REQ-014 Transitions SHALL be: IDLE: valid&hwrite->WWAIT, valid&!hwrite->READ, else IDLE.
REQ-015 Transitions SHALL be: READ->RENABLE unconditionally; WRITEP->WENABLEP unconditionally.
REQ-016 Transitions SHALL be: WWAIT: valid->WRITEP, else WRITE; WRITE: valid->WENABLEP, else WENABLE.
REQ-017 Transitions SHALL be: RENABLE and WENABLE: valid&!hwrite->READ, valid&hwrite->WWAIT, !valid->IDLE.
REQ-018 Transitions SHALL be: WENABLEP: !hwrite_reg_1->READ, hwrite_reg_1&valid->WRITEP, hwrite_reg_1&!valid->WRITE.
REQ-019 All outputs SHALL be registered and valid throughout the cycle the FSM occupies the named state.
REQ-020 Setup states (READ, WRITE, WRITEP) SHALL drive penable=0 and psel=decode(paddr).
REQ-021 Enable states (RENABLE, WENABLE, WENABLEP) SHALL drive penable=1 and hold paddr, pwdata, pwrite and psel from the preceding setup state.
REQ-022 IDLE and WWAIT SHALL drive psel=000 and penable=0, leaving paddr, pwdata and pwrite at their previous values.
REQ-023 On entry to READ, paddr SHALL load haddr and pwrite SHALL load 0.
REQ-024 On entry to WRITE/WRITEP from WWAIT, paddr<=haddr_1, pwdata<=hwdata and pwrite<=1.
REQ-025 On entry to WRITE/WRITEP from WENABLEP, paddr<=haddr_2, pwdata<=hwdata_1 and pwrite<=1.
REQ-026 decode SHALL map paddr[31:26]: 6'h20->001, 6'h21->010, 6'h22->100, any other->000, so an out-of-range address runs the FSM with no peripheral selected.
REQ-027 hreadyout SHALL be 0 in READ and WRITEP and 1 in all other states.
REQ-028 No counters or arithmetic; all data paths SHALL be straight 32-bit register loads with no width conversion.

Reset
REQ-029 While hreset=1, independent of hclk: state=IDLE, psel=000, penable=0, pwrite=0, paddr=0, pwdata=0, hreadyout=1.
REQ-030 Reset asserted mid-transfer (any state) SHALL abort immediately with no completing enable phase; the first edge after deassertion SHALL evaluate the IDLE transitions.

Verification
REQ-031 Single read: IDLE, valid=1, hwrite=0, haddr=0x8000_0010 -> next cycle READ with psel=001, paddr=0x8000_0010, penable=0, hreadyout=0; following cycle RENABLE with penable=1, hreadyout=1; then IDLE.
REQ-032 Single write: valid=1, hwrite=1, haddr=0x8400_0004, then valid=0 with haddr_1=0x8400_0004, hwdata=0xDEAD_BEEF -> WWAIT, then WRITE with psel=010, pwrite=1, pwdata=0xDEAD_BEEF, then WENABLE with penable=1, then IDLE.
REQ-033 Back-to-back writes to 0x8800_0000 and 0x8800_0004 -> WWAIT, WRITEP (hreadyout=0, paddr=0x8800_0000), WENABLEP, then WRITE with paddr=haddr_2=0x8800_0004, pwdata=hwdata_1, psel=100.
REQ-034 Write followed by read: in WENABLEP with hwrite_reg_1=0 -> next state READ, pwrite=0, paddr=haddr.
REQ-035 Out-of-range read at haddr=0x9000_0000 -> READ/RENABLE sequence runs with psel=000.
REQ-036 Reset pulse asserted during WENABLE -> outputs reach reset values without waiting for a clock edge; a read presented after deassertion completes per REQ-031.
